// File: rtl/op_selector_if.sv
// Front-panel bus between the raw push buttons and the operation selector outputs.
// The master drives the buttons. The slave (op_selector) drives the op code and the lock status.
interface op_selector_if;
  logic btn_next_n;
  logic btn_prev_n;
  logic btn_confirm_n;
  logic op_a;
  logic op_b;
  logic op_c;
  logic locked;
  logic op_valid;

  modport master (
    output btn_next_n, btn_prev_n, btn_confirm_n,
    input  op_a, op_b, op_c, locked, op_valid
  );

  modport slave (
    input  btn_next_n, btn_prev_n, btn_confirm_n,
    output op_a, op_b, op_c, locked, op_valid
  );
endinterface

// File: rtl/op_selector.sv
// Debounced front-panel operation selector: next/prev step a wrapping op code.
// Confirm toggles a lock and pulses op_valid when the lock engages.
module op_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_OPS         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  op_selector_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]        MAX_OP   = 3'(NUM_OPS - 1);

  typedef enum logic {
    SELECT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Button index: 0 = next, 1 = prev, 2 = confirm.
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       deb_r;
  logic [2:0]       deb_d_r;
  logic [2:0]       press_r;
  logic [CNT_W-1:0] cnt_r [3];

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] op_r;
  logic [2:0] op_next_s;
  logic       locked_r;
  logic       locked_next_s;
  logic       op_valid_r;
  logic       op_valid_next_s;

  assign raw_s = {bus.btn_confirm_n, bus.btn_prev_n, bus.btn_next_n};

  // Synchronize, debounce and edge-detect all three buttons.
  // The press strobe is registered to keep the decode path off the FSM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      deb_r   <= 3'b111;
      deb_d_r <= 3'b111;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_d_r & ~deb_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            deb_r[i] <= ~deb_r[i];
            cnt_r[i] <= CNT_ZERO;
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
          end
        end else begin
          cnt_r[i] <= CNT_ZERO;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SELECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic: confirm toggles between SELECT and LOCKED.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SELECT: begin
        if (press_r[2]) state_next_s = LOCKED;
        else            state_next_s = SELECT;
      end
      LOCKED: begin
        if (press_r[2]) state_next_s = SELECT;
        else            state_next_s = LOCKED;
      end
      default: state_next_s = SELECT;
    endcase
  end

  // FSM output logic: op stepping only in SELECT, and confirm takes priority over stepping.
  always_comb begin
    op_next_s       = op_r;
    locked_next_s   = (state_next_s == LOCKED);
    op_valid_next_s = (state_r == SELECT) && (state_next_s == LOCKED);
    if ((state_r == SELECT) && !press_r[2]) begin
      case (press_r[1:0])
        2'b01:   op_next_s = (op_r == MAX_OP) ? 3'd0 : op_r + 3'd1;
        2'b10:   op_next_s = (op_r == 3'd0) ? MAX_OP : op_r - 3'd1;
        default: op_next_s = op_r;
      endcase
    end else begin
      op_next_s = op_r;
    end
  end

  // Output registers, so the decoder only ever sees clean flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 3'd0;
      locked_r   <= 1'b0;
      op_valid_r <= 1'b0;
    end else begin
      op_r       <= op_next_s;
      locked_r   <= locked_next_s;
      op_valid_r <= op_valid_next_s;
    end
  end

  assign bus.op_a     = op_r[2];
  assign bus.op_b     = op_r[1];
  assign bus.op_c     = op_r[0];
  assign bus.locked   = locked_r;
  assign bus.op_valid = op_valid_r;

endmodule

// File: doc/op_selector.md
Name: op_selector

Overview:
- Front-panel operation selector for the ULA. It sits directly upstream of the operation-symbol 7-segment decoder and the ALU operation mux.
- It debounces three active-low push buttons (next, prev, confirm) and steps a 3-bit operation code up or down with wrap-around.
- On confirm it locks the code and emits a one-cycle valid pulse.
- op_a/op_b/op_c drive the decoder's A/B/C inputs directly, with op_a as the MSB.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a button level change (10 ms at 50 MHz). Legal range is >= 1.
- NUM_OPS, 8, number of selectable operation codes (0..NUM_OPS-1). Legal range is 2..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_next_n  input  1  raw "next operation" button; asynchronous, active-low (0 = pressed).
- btn_prev_n  input  1  raw "previous operation" button; asynchronous, active-low.
- btn_confirm_n  input  1  raw "confirm/unlock" button; asynchronous, active-low.
- op_a  output  1  operation code bit 2 (MSB), to decoder input A.
- op_b  output  1  operation code bit 1, to decoder input B.
- op_c  output  1  operation code bit 0 (LSB), to decoder input C.
- locked  output  1  1 = code is frozen and the ALU may execute it.
- op_valid  output  1  one-cycle pulse on the cycle locked rises.

Behaviour:
- **Reset** (rst_n = 0, asynchronous):
  - op = 3'b000, locked = 0, op_valid = 0.
  - All synchronizer flops are preset to 1 (released); debounced states = 1; debounce counters = 0.
  - Reset asserted mid-debounce or while locked discards all in-flight state. Release is synchronous to clk.
- **Synchronizer:** each button passes through 2 flops before any other logic.
- **Debounce** (per button, independent):
  - The counter increments each cycle the synchronized level differs from the debounced state, and clears when they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no flip.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- **Press event:** a single-cycle strobe on a debounced 1->0 transition. Release transitions generate nothing. Holding a button produces exactly one event (no auto-repeat).
- **Latency:** a clean press held from clk edge k produces a visible op/locked change at edge k + DEBOUNCE_CYCLES + 3.
- **FSM states:** SELECT (reset state) and LOCKED.
- **In SELECT:**
  - next event: op <= (op == NUM_OPS-1) ? 0 : op+1.
  - prev event: op <= (op == 0) ? NUM_OPS-1 : op-1.
  - next and prev events in the same cycle: op unchanged.
  - confirm event: go to LOCKED, locked <= 1, op_valid <= 1 for exactly one cycle. A next/prev event in that same cycle is ignored, and op keeps its pre-confirm value.
- **In LOCKED:**
  - next/prev events are ignored; op is held.
  - confirm event: go to SELECT, locked <= 0, op unchanged, op_valid stays 0.
- **op_valid:** high only on the first cycle of LOCKED; it is registered, never combinational.
- **Output registers:** op_a/op_b/op_c/locked come straight from registers, so the decoder sees glitch-free inputs.
- **op arithmetic:** op is a 3-bit unsigned register and never takes a value >= NUM_OPS. Wrap-around is computed against NUM_OPS-1, not 7.

Test Plan (bench uses DEBOUNCE_CYCLES=4, NUM_OPS=8 unless noted):
1. **Reset and next press.** Hold rst_n=0, then release; press btn_next_n clean for 10 cycles.
   - During reset: op=000, locked=0, op_valid=0.
   - op=001 exactly 7 edges after the press starts; then a single step only while held.
2. **Wrap and glitch rejection.**
   - From op=111, press next -> op=000. From 000, press prev -> 111.
   - A 3-cycle low glitch on btn_next_n -> no change.
3. **Simultaneous next and prev.** Assert both on the same cycle -> op unchanged. Then press confirm -> locked=1, op_valid high for exactly 1 cycle.
4. **LOCKED behaviour.**
   - While locked, press next and prev -> op held.
   - Press confirm -> locked=0, op_valid=0, op unchanged.
   - Next press then advances op again.
5. **NUM_OPS=6.**
   - From op=101, next -> 000; from 000, prev -> 101.
   - Values 110/111 are never observed on op_a/op_b/op_c.
6. **Reset mid-operation.**
   - Assert rst_n=0 mid-debounce of next while locked with op=011 -> immediately op=000, locked=0.
   - After release, the still-held button needs the full DEBOUNCE_CYCLES+3 again before op changes.
